// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control unit: FSM states, opcodes,
// funct codes, ALU operations and datapath mux selects.
package mc_ctrl_pkg;

   typedef enum logic [3:0] {
      FETCH    = 4'd0,
      DECODE   = 4'd1,
      MEMADR   = 4'd2,
      MEMREAD  = 4'd3,
      MEMWB    = 4'd4,
      MEMWRITE = 4'd5,
      EXECUTE  = 4'd6,
      ALUWB    = 4'd7,
      BRANCH   = 4'd8,
      ADDIEX   = 4'd9,
      ADDIWB   = 4'd10,
      JUMP     = 4'd11,
      HALT     = 4'd12
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [5:0] FUNCT_ADD = 6'b100000;
   localparam logic [5:0] FUNCT_SUB = 6'b100010;
   localparam logic [5:0] FUNCT_AND = 6'b100100;
   localparam logic [5:0] FUNCT_OR  = 6'b100101;
   localparam logic [5:0] FUNCT_SLT = 6'b101010;

   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_SLT = 3'b111;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [1:0] SRCB_REG   = 2'b00;
   localparam logic [1:0] SRCB_FOUR  = 2'b01;
   localparam logic [1:0] SRCB_IMM   = 2'b10;
   localparam logic [1:0] SRCB_IMMSH = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   // Unrecognised funct codes fall back to add so stray R-types stay harmless.
   function automatic logic [2:0] functToAlu(input logic [5:0] funct);
      case (funct)
         FUNCT_SUB: functToAlu = ALU_SUB;
         FUNCT_AND: functToAlu = ALU_AND;
         FUNCT_OR:  functToAlu = ALU_OR;
         FUNCT_SLT: functToAlu = ALU_SLT;
         default:   functToAlu = ALU_ADD;
      endcase
   endfunction

endpackage

// File: rtl/mc_alu_decoder.sv
// ALU decoder: turns the FSM's two-bit aluop request plus funct into the
// three-bit alu_control code shared with the single-cycle design.
module mc_alu_decoder
   import mc_ctrl_pkg::*;
(
   input  logic [1:0] aluop,
   input  logic [5:0] funct,
   output logic [2:0] alu_control
);

   always_comb begin
      alu_control = ALU_ADD;
      case (aluop)
         ALUOP_SUB:   alu_control = ALU_SUB;
         ALUOP_FUNCT: alu_control = functToAlu(funct);
         default:     alu_control = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle MIPS control FSM with memory-ready wait states.
// Define MC_ILLEGAL_TRAP_EN to trap unknown opcodes in HALT with an illegal_op flag.
module mc_control_fsm
   import mc_ctrl_pkg::*;
#(
   parameter logic [3:0] RESET_STATE = 4'd0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] op,
   input  logic [5:0] funct,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       pcen,
   output logic       iord,
   output logic       irwrite,
   output logic       memwrite,
   output logic       regdst,
   output logic       memtoreg,
   output logic       regwrite,
   output logic       alusrca,
   output logic [1:0] alusrcb,
   output logic [1:0] pcsrc,
   output logic [2:0] alu_control,
`ifdef MC_ILLEGAL_TRAP_EN
   output logic       illegal_op,
`endif
   output logic [3:0] state_o
);

   state_t     state_q, state_d;
   logic       pcWriteRaw, branchRaw, iordRaw, irWriteRaw, memWriteRaw;
   logic       regDstRaw, memToRegRaw, regWriteRaw, aluSrcARaw, illegalRaw;
   logic [1:0] aluSrcBRaw, pcSrcRaw, aluOp;
   logic [2:0] aluControlRaw;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= state_t'(RESET_STATE);
      else        state_q <= state_d;
   end

   always_comb begin
      state_d     = state_q;
      pcWriteRaw  = 1'b0;
      branchRaw   = 1'b0;
      iordRaw     = 1'b0;
      irWriteRaw  = 1'b0;
      memWriteRaw = 1'b0;
      regDstRaw   = 1'b0;
      memToRegRaw = 1'b0;
      regWriteRaw = 1'b0;
      aluSrcARaw  = 1'b0;
      illegalRaw  = 1'b0;
      aluSrcBRaw  = SRCB_REG;
      pcSrcRaw    = PCSRC_ALU;
      aluOp       = ALUOP_ADD;
      case (state_q)
         FETCH: begin
            aluSrcBRaw = SRCB_FOUR;
            if (mem_ready) begin
               irWriteRaw = 1'b1;
               pcWriteRaw = 1'b1;
               state_d    = DECODE;
            end
         end
         // ALU precomputes the branch target while the opcode is decoded.
         DECODE: begin
            aluSrcBRaw = SRCB_IMMSH;
            case (op)
               OP_LW, OP_SW: state_d = MEMADR;
               OP_RTYPE:     state_d = EXECUTE;
               OP_BEQ:       state_d = BRANCH;
               OP_ADDI:      state_d = ADDIEX;
               OP_J:         state_d = JUMP;
`ifdef MC_ILLEGAL_TRAP_EN
               default:      state_d = HALT;
`else
               default:      state_d = FETCH;
`endif
            endcase
         end
         MEMADR: begin
            aluSrcARaw = 1'b1;
            aluSrcBRaw = SRCB_IMM;
            state_d    = (op == OP_SW) ? MEMWRITE : MEMREAD;
         end
         MEMREAD: begin
            iordRaw = 1'b1;
            if (mem_ready) state_d = MEMWB;
         end
         MEMWB: begin
            memToRegRaw = 1'b1;
            regWriteRaw = 1'b1;
            state_d     = FETCH;
         end
         MEMWRITE: begin
            iordRaw     = 1'b1;
            memWriteRaw = 1'b1;
            if (mem_ready) state_d = FETCH;
         end
         EXECUTE: begin
            aluSrcARaw = 1'b1;
            aluOp      = ALUOP_FUNCT;
            state_d    = ALUWB;
         end
         ALUWB: begin
            regDstRaw   = 1'b1;
            regWriteRaw = 1'b1;
            state_d     = FETCH;
         end
         BRANCH: begin
            aluSrcARaw = 1'b1;
            aluOp      = ALUOP_SUB;
            branchRaw  = 1'b1;
            pcSrcRaw   = PCSRC_ALUOUT;
            state_d    = FETCH;
         end
         ADDIEX: begin
            aluSrcARaw = 1'b1;
            aluSrcBRaw = SRCB_IMM;
            state_d    = ADDIWB;
         end
         ADDIWB: begin
            regWriteRaw = 1'b1;
            state_d     = FETCH;
         end
         JUMP: begin
            pcSrcRaw   = PCSRC_JUMP;
            pcWriteRaw = 1'b1;
            state_d    = FETCH;
         end
`ifdef MC_ILLEGAL_TRAP_EN
         HALT: begin
            illegalRaw = 1'b1;
            state_d    = HALT;
         end
`endif
         default: state_d = FETCH;
      endcase
   end

   mc_alu_decoder uAluDecoder (
      .aluop       (aluOp),
      .funct       (funct),
      .alu_control (aluControlRaw)
   );

   // Outputs are forced low while reset is held so no strobe survives an abort.
   always_comb begin
      pcen        = 1'b0;
      iord        = 1'b0;
      irwrite     = 1'b0;
      memwrite    = 1'b0;
      regdst      = 1'b0;
      memtoreg    = 1'b0;
      regwrite    = 1'b0;
      alusrca     = 1'b0;
      alusrcb     = 2'b00;
      pcsrc       = 2'b00;
      alu_control = 3'b000;
      if (rst_n) begin
         pcen        = pcWriteRaw | (branchRaw & zero);
         iord        = iordRaw;
         irwrite     = irWriteRaw;
         memwrite    = memWriteRaw;
         regdst      = regDstRaw;
         memtoreg    = memToRegRaw;
         regwrite    = regWriteRaw;
         alusrca     = aluSrcARaw;
         alusrcb     = aluSrcBRaw;
         pcsrc       = pcSrcRaw;
         alu_control = aluControlRaw;
      end
   end

`ifdef MC_ILLEGAL_TRAP_EN
   assign illegal_op = illegalRaw & rst_n;
`else
   logic unusedIllegal;
   assign unusedIllegal = illegalRaw;
`endif

   assign state_o = state_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Scoreboard bench for mc_control_fsm: each driven cycle pushes its expected
// output vector, which is popped and compared at the following falling edge.
module tb_mc_control_fsm;
   import mc_ctrl_pkg::*;

   typedef struct packed {
      logic       ill;
      logic [3:0] st;
      logic       pcen;
      logic       iord;
      logic       irw;
      logic       mw;
      logic       rdst;
      logic       m2r;
      logic       rw;
      logic       asa;
      logic [1:0] asb;
      logic [1:0] psrc;
      logic [2:0] alu;
   } obs_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [5:0] op;
   logic [5:0] funct;
   logic       zero;
   logic       mem_ready;
   logic       pcen, iord, irwrite, memwrite, regdst, memtoreg, regwrite, alusrca;
   logic [1:0] alusrcb, pcsrc;
   logic [2:0] alu_control;
   logic [3:0] state_o;
   logic       illegalObs;

   obs_t  expQ[$];
   int    assertCount = 0;
   int    failCount   = 0;
   int    irCnt, mwCnt, rwCnt, anyWrCnt;
   string curTag;

   always #5 clk = ~clk;

   mc_control_fsm dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .op          (op),
      .funct       (funct),
      .zero        (zero),
      .mem_ready   (mem_ready),
      .pcen        (pcen),
      .iord        (iord),
      .irwrite     (irwrite),
      .memwrite    (memwrite),
      .regdst      (regdst),
      .memtoreg    (memtoreg),
      .regwrite    (regwrite),
      .alusrca     (alusrca),
      .alusrcb     (alusrcb),
      .pcsrc       (pcsrc),
      .alu_control (alu_control),
`ifdef MC_ILLEGAL_TRAP_EN
      .illegal_op  (illegalObs),
`endif
      .state_o     (state_o)
   );

`ifndef MC_ILLEGAL_TRAP_EN
   assign illegalObs = 1'b0;
`endif

   // Counts a comparison and reports any mismatch on one line.
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      assertCount++;
      if (obs !== exp) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic obs_t packObs();
      obs_t o;
      o.ill  = illegalObs;
      o.st   = state_o;
      o.pcen = pcen;
      o.iord = iord;
      o.irw  = irwrite;
      o.mw   = memwrite;
      o.rdst = regdst;
      o.m2r  = memtoreg;
      o.rw   = regwrite;
      o.asa  = alusrca;
      o.asb  = alusrcb;
      o.psrc = pcsrc;
      o.alu  = alu_control;
      return o;
   endfunction

   function automatic logic [2:0] benchAlu(input logic [5:0] f);
      case (f)
         6'b100010: return 3'b110;
         6'b100100: return 3'b000;
         6'b100101: return 3'b001;
         6'b101010: return 3'b111;
         default:   return 3'b010;
      endcase
   endfunction

   // Reference outputs for one state, written from the control table.
   function automatic obs_t refOutputs(input logic [3:0] st, input logic rdy);
      obs_t e;
      e     = '0;
      e.st  = st;
      e.alu = 3'b010;
      case (st)
         4'd0:  begin e.asb = 2'b01; e.irw = rdy; e.pcen = rdy; end
         4'd1:  e.asb = 2'b11;
         4'd2:  begin e.asa = 1'b1; e.asb = 2'b10; end
         4'd3:  e.iord = 1'b1;
         4'd4:  begin e.m2r = 1'b1; e.rw = 1'b1; end
         4'd5:  begin e.iord = 1'b1; e.mw = 1'b1; end
         4'd6:  begin e.asa = 1'b1; e.alu = benchAlu(funct); end
         4'd7:  begin e.rdst = 1'b1; e.rw = 1'b1; end
         4'd8:  begin e.asa = 1'b1; e.alu = 3'b110; e.psrc = 2'b01; e.pcen = zero; end
         4'd9:  begin e.asa = 1'b1; e.asb = 2'b10; end
         4'd10: e.rw = 1'b1;
         4'd11: begin e.psrc = 2'b10; e.pcen = 1'b1; end
         4'd12: e.ill = 1'b1;
         default: ;
      endcase
      return e;
   endfunction

   // Drives one cycle, pushes its expectation, then pops and checks mid-cycle.
   task automatic applyStimulus(input logic [3:0] expState, input logic rdy);
      obs_t e, o;
      mem_ready = rdy;
      expQ.push_back(refOutputs(expState, rdy));
      @(negedge clk);
      o = packObs();
      if (o.irw) irCnt++;
      if (o.mw)  mwCnt++;
      if (o.rw)  rwCnt++;
      if (o.irw || o.mw || o.rw || o.pcen) anyWrCnt++;
      if (expQ.size() == 0) begin
         checkOutput({curTag, "_queue_empty"}, 32'd1, 32'd0);
      end else begin
         e = expQ.pop_front();
         checkOutput(curTag, 32'(o), 32'(e));
      end
      @(posedge clk);
      #1;
   endtask

   task automatic runInstr(input string name, input logic [5:0] opIn, input logic [5:0] fIn,
                           input logic zIn, input int fetchWaits, input int memWaits);
      curTag = name;
      op     = opIn;
      funct  = fIn;
      zero   = zIn;
      irCnt = 0; mwCnt = 0; rwCnt = 0; anyWrCnt = 0;
      for (int i = 0; i < fetchWaits; i++) applyStimulus(FETCH, 1'b0);
      applyStimulus(FETCH, 1'b1);
      applyStimulus(DECODE, 1'b1);
      case (opIn)
         OP_LW: begin
            applyStimulus(MEMADR, 1'b1);
            for (int i = 0; i < memWaits; i++) applyStimulus(MEMREAD, 1'b0);
            applyStimulus(MEMREAD, 1'b1);
            applyStimulus(MEMWB, 1'b1);
         end
         OP_SW: begin
            applyStimulus(MEMADR, 1'b1);
            for (int i = 0; i < memWaits; i++) applyStimulus(MEMWRITE, 1'b0);
            applyStimulus(MEMWRITE, 1'b1);
         end
         OP_RTYPE: begin
            applyStimulus(EXECUTE, 1'b1);
            applyStimulus(ALUWB, 1'b1);
         end
         OP_BEQ:  applyStimulus(BRANCH, 1'b1);
         OP_ADDI: begin
            applyStimulus(ADDIEX, 1'b1);
            applyStimulus(ADDIWB, 1'b1);
         end
         OP_J:    applyStimulus(JUMP, 1'b1);
         default: begin
`ifdef MC_ILLEGAL_TRAP_EN
            for (int i = 0; i < 4; i++) applyStimulus(HALT, 1'(i % 2));
`endif
         end
      endcase
   endtask

   // Asserts reset between edges, checks all outputs drop at once, then releases.
   task automatic pulseReset(input string tag);
      mem_ready = 1'b0;
      rst_n     = 1'b0;
      #1;
      checkOutput(tag, 32'(packObs()), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [5:0] functList [5];
      functList[0] = 6'b100000;
      functList[1] = 6'b100100;
      functList[2] = 6'b100101;
      functList[3] = 6'b101010;
      functList[4] = 6'b000111;

      rst_n = 1'b0; op = '0; funct = '0; zero = 1'b0; mem_ready = 1'b1;
      #3;
      checkOutput("reset_outputs", 32'(packObs()), 32'd0);
      mem_ready = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      runInstr("rtype_sub", OP_RTYPE, 6'b100010, 1'b0, 0, 0);
      checkOutput("rtype_regwrite_cycles", 32'(rwCnt), 32'd1);

      for (int i = 0; i < 5; i++) runInstr("rtype_funct", OP_RTYPE, functList[i], 1'b0, 0, 0);

      runInstr("lw_waits", OP_LW, 6'b000000, 1'b0, 2, 3);
      checkOutput("lw_irwrite_pulses", 32'(irCnt), 32'd1);
      checkOutput("lw_regwrite_cycles", 32'(rwCnt), 32'd1);

      runInstr("sw_wait", OP_SW, 6'b000000, 1'b0, 0, 1);
      checkOutput("sw_memwrite_cycles", 32'(mwCnt), 32'd2);
      checkOutput("sw_regwrite_cycles", 32'(rwCnt), 32'd0);

      runInstr("beq_taken", OP_BEQ, 6'b000000, 1'b1, 0, 0);
      runInstr("beq_not_taken", OP_BEQ, 6'b000000, 1'b0, 0, 0);
      runInstr("addi", OP_ADDI, 6'b000000, 1'b0, 1, 0);
      runInstr("jump", OP_J, 6'b000000, 1'b0, 0, 0);

      // Abort an R-type while it sits in EXECUTE.
      curTag = "rst_mid_pre";
      op = OP_RTYPE; funct = 6'b100010; zero = 1'b0;
      applyStimulus(FETCH, 1'b1);
      applyStimulus(DECODE, 1'b1);
      checkOutput("rst_mid_in_execute", 32'(state_o), 32'd6);
      pulseReset("rst_mid_outputs");
      runInstr("after_reset", OP_ADDI, 6'b000000, 1'b0, 0, 0);

      runInstr("illegal_op", 6'b111111, 6'b000000, 1'b0, 0, 0);
`ifndef MC_ILLEGAL_TRAP_EN
      checkOutput("illegal_no_writes", 32'(anyWrCnt - 1), 32'd0);
`else
      checkOutput("illegal_held", 32'(state_o), 32'd12);
`endif
      pulseReset("illegal_reset_outputs");
      runInstr("post_illegal", OP_J, 6'b000000, 1'b0, 0, 0);

      checkOutput("queue_drained", 32'(expQ.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL timeout: got no finish, expected finish");
      $fatal(1, "[TB] simulation time limit reached");
   end

endmodule
